// File: rtl/quad_encoder_gen.sv
// rtl/quad_encoder_gen.sv - quadrature A/B waveform generator with start/busy/done handshake
// Emits a commanded number of quarter-steps at a fixed rate and tracks signed position.
module quad_encoder_gen #(
  parameter int PER_W  = 8,
  parameter int STEP_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              dir_ccw,
  input  logic [PER_W-1:0]  period,
  input  logic [STEP_W-1:0] steps,
  input  logic              abort,
  output logic              A,
  output logic              B,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] position
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_n;
  logic [1:0]          phase, phase_n;
  logic [PER_W-1:0]    timer, timer_n;
  logic [PER_W-1:0]    period_l, period_l_n;
  logic [STEP_W-1:0]   remaining, remaining_n;
  logic [STEP_W-1:0]   position_n;
  logic                dir_l, dir_l_n;
  logic                busy_n, done_n;

  // Gray-code walk of {A,B}; CW: 00->10->11->01, CCW is the reverse.
  function automatic logic [1:0] advance(input logic [1:0] ph, input logic ccw);
    logic [1:0] nx;
    if (!ccw) begin
      case (ph)
        2'b00:   nx = 2'b10;
        2'b10:   nx = 2'b11;
        2'b11:   nx = 2'b01;
        default: nx = 2'b00;
      endcase
    end else begin
      case (ph)
        2'b00:   nx = 2'b01;
        2'b01:   nx = 2'b11;
        2'b11:   nx = 2'b10;
        default: nx = 2'b00;
      endcase
    end
    return nx;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= 2'b00;
      timer     <= '0;
      period_l  <= PER_W'(1);
      remaining <= '0;
      position  <= '0;
      dir_l     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      timer     <= timer_n;
      period_l  <= period_l_n;
      remaining <= remaining_n;
      position  <= position_n;
      dir_l     <= dir_l_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    timer_n     = timer;
    period_l_n  = period_l;
    remaining_n = remaining;
    position_n  = position;
    dir_l_n     = dir_l;
    busy_n      = busy;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (steps == '0) begin
            done_n = 1'b1;
          end else begin
            dir_l_n     = dir_ccw;
            period_l_n  = (period == '0) ? PER_W'(1) : period;
            remaining_n = steps;
            timer_n     = '0;
            busy_n      = 1'b1;
            state_n     = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (timer == period_l - PER_W'(1)) begin
          timer_n     = '0;
          phase_n     = advance(phase, dir_l);
          remaining_n = remaining - STEP_W'(1);
          position_n  = dir_l ? position - STEP_W'(1) : position + STEP_W'(1);
          if (remaining == STEP_W'(1)) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end else begin
          timer_n = timer + PER_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign A = phase[1];
  assign B = phase[0];

endmodule

// File: tb/tb_quad_encoder_gen.sv
// tb/tb_quad_encoder_gen.sv - self-checking bench for quad_encoder_gen
// Expected waveforms come from step arithmetic: steps done = min(cycles / period, steps).
module tb_quad_encoder_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        dir_ccw = 1'b0;
  logic [7:0]  period = '0;
  logic [15:0] steps = '0;
  logic        abort = 1'b0;
  logic        A, B, busy, done;
  logic [15:0] position;

  int vectors = 0;
  int miscompares = 0;
  int m_idx = 0;
  logic [15:0] m_pos = '0;

  quad_encoder_gen #(.PER_W(8), .STEP_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .dir_ccw(dir_ccw),
    .period(period), .steps(steps), .abort(abort),
    .A(A), .B(B), .busy(busy), .done(done), .position(position)
  );

  always #5 clock = ~clock;

  function automatic logic [1:0] ab_of(input int idx);
    int k;
    k = ((idx % 4) + 4) % 4;
    case (k)
      0: return 2'b00;
      1: return 2'b10;
      2: return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_cmd(input logic ccw, input int per, input int st, input string name);
    int pl, total, n, cmax;
    logic [1:0]  eab;
    logic [15:0] epos, nv;
    logic ebusy, edone;
    pl = (per == 0) ? 1 : per;
    total = pl * st;
    cmax = total + 1;
    dir_ccw = ccw;
    period = per[7:0];
    steps = st[15:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= cmax; c++) begin
      if (c > 0) tick();
      n = c / pl;
      if (n > st) n = st;
      nv = n[15:0];
      eab = ab_of(ccw ? m_idx - n : m_idx + n);
      epos = ccw ? m_pos - nv : m_pos + nv;
      ebusy = (st != 0) && (c < total);
      edone = (st == 0) ? (c == 0) : (c == total);
      vectors++;
      if ({A, B, busy, done, position} !== {eab, ebusy, edone, epos}) begin
        miscompares++;
        $display("FAIL %s c=%0d got ab=%b busy=%b done=%b pos=%h exp ab=%b busy=%b done=%b pos=%h",
                 name, c, {A, B}, busy, done, position, eab, ebusy, edone, epos);
      end
    end
    m_idx = ((ccw ? m_idx - st : m_idx + st) % 4 + 4) % 4;
    m_pos = ccw ? m_pos - st[15:0] : m_pos + st[15:0];
  endtask

  task automatic do_reset();
    #3 reset = 1'b1;
    tick();
    reset = 1'b0;
    m_idx = 0;
    m_pos = '0;
  endtask

  task automatic test_reset();
    tick();
    reset = 1'b0;
    dir_ccw = 1'b0; period = 8'd2; steps = 16'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #3 reset = 1'b1;
    #1;
    vectors++;
    if ({A, B, busy, done, position} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_async got ab=%b busy=%b done=%b pos=%h exp all zero",
               {A, B}, busy, done, position);
    end
    tick();
    reset = 1'b0;
    m_idx = 0;
    m_pos = '0;
  endtask

  task automatic test_cw();
    run_cmd(1'b0, 3, 4, "cw_run");
    vectors++;
    if (position !== 16'd4) begin
      miscompares++;
      $display("FAIL cw_pos got %h exp 0004", position);
    end
  endtask

  task automatic test_ccw();
    run_cmd(1'b1, 0, 2, "ccw_run_period0");
    vectors++;
    if ({A, B, position} !== {2'b11, 16'd2}) begin
      miscompares++;
      $display("FAIL ccw_end got ab=%b pos=%h exp ab=11 pos=0002", {A, B}, position);
    end
  endtask

  task automatic test_zero_steps();
    run_cmd(1'b0, 4, 0, "zero_steps");
  endtask

  task automatic test_abort();
    logic [1:0]  eab;
    logic [15:0] epos;
    logic ebusy;
    int n;
    do_reset();
    dir_ccw = 1'b0; period = 8'd5; steps = 16'd10; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (c == 7) begin
        start = 1'b1; dir_ccw = 1'b1; period = 8'd1; steps = 16'd3;
      end else begin
        start = 1'b0;
      end
      abort = (c == 12);
      tick();
      n = (c < 12) ? c / 5 : 2;
      eab = ab_of(n);
      epos = n[15:0];
      ebusy = (c < 12);
      vectors++;
      if ({A, B, busy, done, position} !== {eab, ebusy, 1'b0, epos}) begin
        miscompares++;
        $display("FAIL abort c=%0d got ab=%b busy=%b done=%b pos=%h exp ab=%b busy=%b done=0 pos=%h",
                 c, {A, B}, busy, done, position, eab, ebusy, epos);
      end
    end
    abort = 1'b0;
    m_idx = 2;
    m_pos = 16'd2;
    start = 1'b1; abort = 1'b1; steps = 16'd5; period = 8'd1; dir_ccw = 1'b0;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    vectors++;
    if ({A, B, busy, done, position} !== {2'b11, 1'b0, 1'b0, 16'd2}) begin
      miscompares++;
      $display("FAIL start_abort_idle got ab=%b busy=%b done=%b pos=%h exp ab=11 busy=0 done=0 pos=0002",
               {A, B}, busy, done, position);
    end
  endtask

  task automatic test_wrap_loopback();
    int rises, first_rise, gap;
    logic prev_a;
    do_reset();
    run_cmd(1'b1, 2, 1, "wrap_ccw");
    vectors++;
    if (position !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL wrap_pos got %h exp ffff", position);
    end
    rises = 0; first_rise = 0; gap = 0;
    prev_a = A;
    dir_ccw = 1'b0; period = 8'd4; steps = 16'd8; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      tick();
      if (A && !prev_a) begin
        vectors++;
        if (B !== 1'b0) begin
          miscompares++;
          $display("FAIL loopback_dir c=%0d got B=%b at A rise exp 0", c, B);
        end
        if (rises == 0) first_rise = c;
        else gap = c - first_rise;
        rises++;
      end
      prev_a = A;
    end
    vectors++;
    if (rises != 2 || gap - 1 != 15) begin
      miscompares++;
      $display("FAIL loopback_omega got rises=%0d omega=%0d exp rises=2 omega=15", rises, gap - 1);
    end
    m_idx = 3;
    m_pos = 16'd7;
    vectors++;
    if (position !== m_pos) begin
      miscompares++;
      $display("FAIL loopback_pos got %h exp %h", position, m_pos);
    end
  endtask

  task automatic test_random();
    logic ccw;
    int per, st;
    for (int i = 0; i < 20; i++) begin
      ccw = 1'($urandom_range(0, 1));
      per = $urandom_range(0, 6);
      st = $urandom_range(0, 9);
      run_cmd(ccw, per, st, "random");
    end
  endtask

  task automatic test_back_to_back_zero();
    steps = 16'd0; period = 8'd3; start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    vectors++;
    if ({done, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL zero_b2b got done=%b busy=%b exp done=1 busy=0", done, busy);
    end
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_b2b_end got done=%b exp 0", done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_cw();
    test_ccw();
    test_zero_steps();
    test_abort();
    test_wrap_loopback();
    test_back_to_back_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
